multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none.
REQ-002 One clock; reset is asynchronous and active-low (clk, rst_n); all state updates on rising clk edge.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  async active-low reset.
REQ-005 op  input  7  opcode from instruction register; stable from DECODE until next FETCH.
REQ-006 funct3  input  3; funct7b5  input  1  instruction fields.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath strobes/selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath muxes.
REQ-010 AluControl  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
REQ-011 InstrDone  output  1  one-cycle pulse on final state of each instruction; Illegal  output  1  trap flag.

Function
REQ-012 Moore FSM; outputs decoded from state (plus op/funct only where stated); states RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP.
REQ-013 Unlisted outputs are 0 in every state; mux encodings: ALUSrcA 00 PC/01 OldPC/10 rs1; ALUSrcB 00 rs2/01 imm/10 const 4; ResultSrc 00 ALUOut/01 Data/10 ALUResult.
REQ-014 RST -> FETCH unconditionally.
REQ-015 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, add; -> DECODE.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, add; next by op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1101111 JAL, 1100011 BEQ, other TRAP.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, add; -> MEMREAD if op=0000011 else MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1 -> MEMWB; MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1 -> FETCH.
REQ-019 MEMWRITE: AdrSrc=1, MemWrite=1, InstrDone=1 -> FETCH.
REQ-020 EXECUTER: ALUSrcA=10, ALUSrcB=00; EXECUTEI: ALUSrcA=10, ALUSrcB=01; both AluControl per REQ-023; -> ALUWB.
REQ-021 JAL: ALUSrcA=01, ALUSrcB=10, add, PCWrite=1 -> ALUWB; ALUWB: RegWrite=1, InstrDone=1 -> FETCH.
REQ-022 BEQ: ALUSrcA=10, ALUSrcB=00, sub, PCWrite=zero (same cycle), InstrDone=1 -> FETCH.
REQ-023 funct decode: 000 sub if op=0110011 and funct7b5=1 else add; 001 sll; 010 slt; 100 xor; 101 srl; 110 or; 111 and; 011 add.
REQ-024 ImmSrc combinational from op in all states: 0100011 01, 1100011 10, 1101111 11, else 00.
REQ-025 TRAP: Illegal=1, all strobes 0; sticky until rst_n low.
REQ-026 Latency FETCH-to-FETCH: lw 5, sw/R/I/jal 4, beq 3 cycles.
REQ-027 Unused state encodings -> TRAP next cycle.

Reset
REQ-028 rst_n low forces RST immediately regardless of clk, aborting any instruction; all outputs 0 (ImmSrc per op) while low.
REQ-029 First edge after rst_n deasserts enters FETCH; no strobe asserted during reset or in RST.

Verification
REQ-030 rst_n low 3 cycles then high, op=0000011 -> RST 1 cycle, FETCH with IRWrite=PCWrite=1, no MemWrite/RegWrite during reset.
REQ-031 op=0000011 lw -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5, InstrDone once.
REQ-032 op=0110011, funct3=000, funct7b5=1 -> AluControl=001 in EXECUTER; funct7b5=1 with op=0010011 -> AluControl=000; funct3=010 -> 101.
REQ-033 op=1100011 with zero=1 -> PCWrite=1 in BEQ cycle; zero=0 -> PCWrite=0; both 3 cycles.
REQ-034 op=1111111 -> TRAP after DECODE, Illegal=1 held 20 cycles, cleared only by rst_n.
REQ-035 rst_n pulsed low mid-MEMWRITE (async, between edges) -> MemWrite drops immediately, restart at RST/FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing a multicycle RISC-V style datapath
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] AluControl,
    output logic       InstrDone,
    output logic       Illegal
);
    localparam logic [6:0] opLoad   = 7'b0000011;
    localparam logic [6:0] opStore  = 7'b0100011;
    localparam logic [6:0] opR      = 7'b0110011;
    localparam logic [6:0] opI      = 7'b0010011;
    localparam logic [6:0] opJal    = 7'b1101111;
    localparam logic [6:0] opBranch = 7'b1100011;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP
    } stateT;

    stateT state, nextState;
    logic [2:0] functAlu;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= RST;
        else        state <= nextState;

    // only register-register subtract uses funct7b5; immediates never subtract
    always_comb
        case (funct3)
            3'b000:  functAlu = (op == opR && funct7b5) ? 3'b001 : 3'b000;
            3'b001:  functAlu = 3'b110;
            3'b010:  functAlu = 3'b101;
            3'b100:  functAlu = 3'b100;
            3'b101:  functAlu = 3'b111;
            3'b110:  functAlu = 3'b011;
            3'b111:  functAlu = 3'b010;
            default: functAlu = 3'b000;
        endcase

    assign ImmSrc = op == opStore  ? 2'b01 :
                    op == opBranch ? 2'b10 :
                    op == opJal    ? 2'b11 : 2'b00;

    always_comb
        case (state)
            RST:      nextState = FETCH;
            FETCH:    nextState = DECODE;
            DECODE:   nextState = (op == opLoad || op == opStore) ? MEMADR :
                                  op == opR      ? EXECUTER :
                                  op == opI      ? EXECUTEI :
                                  op == opJal    ? JAL :
                                  op == opBranch ? BEQ : TRAP;
            MEMADR:   nextState = op == opLoad ? MEMREAD : MEMWRITE;
            MEMREAD:  nextState = MEMWB;
            MEMWB:    nextState = FETCH;
            MEMWRITE: nextState = FETCH;
            EXECUTER: nextState = ALUWB;
            EXECUTEI: nextState = ALUWB;
            JAL:      nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            BEQ:      nextState = FETCH;
            default:  nextState = TRAP;
        endcase

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        AluControl = 3'b000;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                AluControl = functAlu;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                AluControl = functAlu;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                AluControl = 3'b001;
                PCWrite    = zero;
                InstrDone  = 1'b1;
            end
            TRAP:    Illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random and directed instruction streams checked against a per-step model
module tb_multicycle_controller;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;
    localparam logic [2:0] aluOf [8] = '{3'b000, 3'b110, 3'b101, 3'b000, 3'b100, 3'b111, 3'b011, 3'b010};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [6:0] op = LW;
    logic [2:0] funct3 = 3'b000;
    logic funct7b5 = 1'b0;
    logic zero = 1'b0;
    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] AluControl;
    logic [17:0] outs, expVec, pinVec;
    logic expValid = 1'b0;
    logic pinValid = 1'b0;
    int checks = 0;
    int fails = 0;
    event chkEv;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .AluControl(AluControl), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, AluControl, InstrDone, Illegal};

    // expected outputs for cycle k of an instruction (k=0 is FETCH, k<0 is reset/RST)
    function automatic logic [17:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input int k);
        logic pcw, adr, mw, irw, rw, done, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        {pcw, adr, mw, irw, rw, done, ill} = '0;
        {rs, sa, sb} = '0;
        alu = 3'b000;
        imm = o == SW ? 2'b01 : o == BQ ? 2'b10 : o == JL ? 2'b11 : 2'b00;
        if (k == 0) begin
            irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10;
        end else if (k == 1) begin
            sa = 2'b01; sb = 2'b01;
        end else if (k >= 2) begin
            if (o == LW || o == SW) begin
                if (k == 2) begin sa = 2'b10; sb = 2'b01; end
                if (k == 3) begin adr = 1'b1; mw = o == SW; done = o == SW; end
                if (k == 4) begin rs = 2'b01; rw = 1'b1; done = 1'b1; end
            end else if (o == RT || o == IT) begin
                if (k == 2) begin
                    sa = 2'b10;
                    sb = o == IT ? 2'b01 : 2'b00;
                    alu = (f3 == 3'b000 && o == RT && f7) ? 3'b001 : aluOf[f3];
                end else begin rw = 1'b1; done = 1'b1; end
            end else if (o == JL) begin
                if (k == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
                else begin rw = 1'b1; done = 1'b1; end
            end else if (o == BQ) begin
                sa = 2'b10; alu = 3'b001; pcw = z; done = 1'b1;
            end else ill = 1'b1;
        end
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, done, ill};
    endfunction

    function automatic int instrLen(input logic [6:0] o);
        return o == LW ? 5 : o == BQ ? 3 : (o == SW || o == RT || o == IT || o == JL) ? 4 : 0;
    endfunction

    always begin
        @(negedge clk or chkEv);
        if (expValid) begin
            checks++;
            if (outs !== expVec) begin
                fails++;
                $display("FAIL model t=%0t op=%b: outputs=%05h expected=%05h", $time, op, outs, expVec);
            end
        end
        if (pinValid) begin
            checks++;
            if (outs !== pinVec) begin
                fails++;
                $display("FAIL pinned t=%0t op=%b: outputs=%05h expected=%05h", $time, op, outs, pinVec);
            end
        end
    end

    // entered just after the edge that starts FETCH; pin window [pf,pt] holds literal pv
    task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int zf, input int n, input int pf, input int pt, input logic [17:0] pv);
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin op = o; funct3 = f3; funct7b5 = f7; end
            zero = zf < 0 ? 1'($urandom) : 1'(zf);
            expVec = model(op, funct3, funct7b5, zero, k);
            pinValid = k >= pf && k <= pt;
            pinVec = pv;
            @(posedge clk); #1;
        end
        pinValid = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        rst_n = 1'b0;
        expVec = model(op, funct3, funct7b5, zero, -1);
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] o;
        #2 rst_n = 1'b0;
        expVec = model(op, funct3, funct7b5, zero, -1);
        expValid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pinVec = 18'h00000;
        pinValid = 1'b1;
        @(posedge clk); #1;
        runInstr(LW, 3'b000, 1'b0, -1, 5, 0, 0, 18'h25100);
        runInstr(LW, 3'b010, 1'b0, -1, 5, 4, 4, 18'h02802);
        runInstr(RT, 3'b000, 1'b1, -1, 4, 2, 2, 18'h00404);
        runInstr(IT, 3'b000, 1'b1, -1, 4, 2, 2, 18'h00480);
        runInstr(RT, 3'b010, 1'b0, -1, 4, 2, 2, 18'h00414);
        runInstr(BQ, 3'b000, 1'b0, 1, 3, 2, 2, 18'h20446);
        runInstr(BQ, 3'b000, 1'b0, 0, 3, 2, 2, 18'h00446);
        runInstr(SW, 3'b010, 1'b0, -1, 3, 9, 9, 18'h0);
        expVec = model(op, funct3, funct7b5, zero, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 expVec = model(op, funct3, funct7b5, zero, -1);
        pinVec = 18'h00020;
        pinValid = 1'b1;
        -> chkEv;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        pinValid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 12))
                0, 1:    o = LW;
                2, 3:    o = SW;
                4, 5:    o = RT;
                6, 7:    o = IT;
                8:       o = JL;
                9, 10:   o = BQ;
                default: o = 7'($urandom);
            endcase
            if (instrLen(o) == 0) begin
                runInstr(o, 3'($urandom), 1'($urandom), -1, 7, 99, 99, 18'h0);
                doReset(2);
            end else runInstr(o, 3'($urandom), 1'($urandom), -1, instrLen(o), 99, 99, 18'h0);
        end
        runInstr(BAD, 3'b000, 1'b0, -1, 22, 2, 21, 18'h00001);
        doReset(1);
        runInstr(JL, 3'b000, 1'b0, -1, 4, 99, 99, 18'h0);
        expValid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
